mem_port_arbiter: RTL

Arbiter and sequencer sharing one single-ported, variable-latency memory between the instruction-fetch stage and the MEM stage of the 5-stage ARM pipeline. It grants one requester at a time, drives the memory handshake, and returns read data with a one-cycle ready pulse. It also produces the combinational stall that freezes the pipeline while any access is outstanding, and it flags memories that never acknowledge.

---
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the fetch, data and memory-side handshake signals
//                that surround the shared memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    // MEM-stage requester
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Shared memory port
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;

    // Pipeline control / status
    logic              stall;
    logic              err;

    // Arbiter side: drives the memory port and the pipeline responses
    modport master (
        input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata,
        input  m_rdata, m_ack,
        output if_rdata, if_ready, mem_rdata, mem_ready,
        output m_req, m_we, m_addr, m_wdata, stall, err
    );

    // Environment side: pipeline requesters plus the memory itself
    modport slave (
        output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata,
        output m_rdata, m_ack,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
        input  m_req, m_we, m_addr, m_wdata, stall, err
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter/sequencer sharing one variable-latency
//                memory between instruction fetch and the MEM stage. Produces
//                the pipeline stall and a sticky no-acknowledge timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    localparam int              CNT_W          = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] C_TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_D_ACC  = 3'd1,
        S_D_RESP = 3'd2,
        S_F_ACC  = 3'd3,
        S_F_RESP = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_DATA  = 1'b0,
        GRANT_FETCH = 1'b1
    } grant_t;

    state_t              state_q, state_d;
    grant_t              last_grant_q, last_grant_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                w_data_req;
    logic                w_in_acc;
    logic                w_mem_ready;
    logic                w_if_ready;

    assign w_data_req  = bus.mem_r_en | bus.mem_w_en;
    assign w_in_acc    = (state_q == S_D_ACC) || (state_q == S_F_ACC);
    assign w_mem_ready = (state_q == S_D_RESP);
    assign w_if_ready  = (state_q == S_F_RESP);

    // Next-state, grant and data-capture decisions
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;

        case (state_q)
            S_IDLE: begin
                // On a tie the requester that was not served last wins
                if (w_data_req && (!bus.if_req || last_grant_q == GRANT_FETCH)) begin
                    m_addr_d     = bus.mem_addr;
                    m_wdata_d    = bus.mem_wdata;
                    m_we_d       = bus.mem_w_en;
                    last_grant_d = GRANT_DATA;
                    state_d      = S_D_ACC;
                end else if (bus.if_req) begin
                    m_addr_d     = bus.if_addr;
                    m_we_d       = 1'b0;
                    last_grant_d = GRANT_FETCH;
                    state_d      = S_F_ACC;
                end
            end

            S_D_ACC, S_F_ACC: begin
                // An acknowledge on the last allowed cycle still counts as success
                if (bus.m_ack) begin
                    if (state_q == S_F_ACC) begin
                        if_rdata_d = bus.m_rdata;
                    end else if (!m_we_q) begin
                        mem_rdata_d = bus.m_rdata;
                    end
                    cnt_d   = '0;
                    state_d = (state_q == S_F_ACC) ? S_F_RESP : S_D_RESP;
                end else if (cnt_q == C_CNT_LAST) begin
                    if (state_q == S_F_ACC) begin
                        if_rdata_d = C_TIMEOUT_DATA;
                    end else begin
                        mem_rdata_d = C_TIMEOUT_DATA;
                    end
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = (state_q == S_F_ACC) ? S_F_RESP : S_D_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_D_RESP, S_F_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_FETCH;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.m_req     = w_in_acc;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_ready  = w_if_ready;
    assign bus.mem_ready = w_mem_ready;
    assign bus.err       = err_q;

    // Freeze the pipeline while any requester is still waiting for its ready
    assign bus.stall = rst & ((w_data_req & ~w_mem_ready) | (bus.if_req & ~w_if_ready));

endmodule

`default_nettype wire
